// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator request/response channel.
// Used by the responder, its command FIFO and the port interface.
package calc_pkg;

  localparam int REQ_CMD_WIDTH  = 4;
  localparam int REQ_DATA_WIDTH = 32;
  localparam int REQ_TAG_WIDTH  = 2;
  localparam int OUT_RESP_WIDTH = 2;

  typedef enum logic [REQ_CMD_WIDTH-1:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } calc_cmd_e;

  typedef enum logic [OUT_RESP_WIDTH-1:0] {
    NONE = 2'd0,
    OK   = 2'd1,
    ERR  = 2'd2
  } calc_resp_e;

  // cmd is kept as a raw vector so invalid opcodes survive queuing.
  typedef struct packed {
    logic [REQ_CMD_WIDTH-1:0]  cmd;
    logic [REQ_TAG_WIDTH-1:0]  tag;
    logic [REQ_DATA_WIDTH-1:0] op1;
    logic [REQ_DATA_WIDTH-1:0] op2;
  } calc_entry_t;

endpackage

// File: rtl/calc_port_responder_if.sv
// Requester-port bundle of the calculator channel: request inputs toward the
// responder and the registered response/drop outputs back to the requester.
interface calc_port_responder_if;
  import calc_pkg::*;

  logic [REQ_CMD_WIDTH-1:0]  ifReq_cmd_in;
  logic [REQ_DATA_WIDTH-1:0] ifReq_data_in;
  logic [REQ_TAG_WIDTH-1:0]  ifReq_tag_in;
  logic [OUT_RESP_WIDTH-1:0] ifResp_out;
  logic [REQ_DATA_WIDTH-1:0] ifData_out;
  logic [REQ_TAG_WIDTH-1:0]  ifTag_out;
  logic                      ifDrop_out;

  modport master (
    output ifReq_cmd_in, ifReq_data_in, ifReq_tag_in,
    input  ifResp_out, ifData_out, ifTag_out, ifDrop_out
  );

  modport slave (
    input  ifReq_cmd_in, ifReq_data_in, ifReq_tag_in,
    output ifResp_out, ifData_out, ifTag_out, ifDrop_out
  );

endinterface

// File: rtl/calc_cmd_fifo.sv
// Synchronous FIFO of accepted calculator requests. A push into a full FIFO
// is still taken when a pop happens in the same cycle.
module calc_cmd_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  calc_entry_t                i_entry,
  input  logic                       i_pop,
  output calc_entry_t                o_entry,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  calc_entry_t   r_mem [DEPTH];

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_entry   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end

endmodule

// File: rtl/calc_port_responder.sv
// Single-port calculator responder: collects two-cycle requests, queues them,
// and returns one registered in-order response per request.
module calc_port_responder
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 ifClk,
  input  logic                 ifRst,
  calc_port_responder_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {IN_IDLE, IN_OPND2} in_state_e;
  typedef enum logic [1:0] {EX_IDLE, EX_EXEC, EX_SHIFT, EX_RESP} ex_state_e;

  in_state_e                 r_in_state, w_in_next;
  logic [REQ_CMD_WIDTH-1:0]  r_req_cmd;
  logic [REQ_TAG_WIDTH-1:0]  r_req_tag;
  logic [REQ_DATA_WIDTH-1:0] r_req_op1;
  logic                      w_push;
  calc_entry_t               w_push_entry;

  ex_state_e                 r_ex_state, w_ex_next;
  logic [REQ_CMD_WIDTH-1:0]  r_cmd;
  logic [REQ_TAG_WIDTH-1:0]  r_tag;
  logic [REQ_DATA_WIDTH-1:0] r_op1, r_op2, r_acc;
  logic [4:0]                r_cnt;
  calc_resp_e                r_resp, w_resp;
  logic [REQ_DATA_WIDTH-1:0] r_data, w_data;
  logic [REQ_TAG_WIDTH-1:0]  r_tag_out;
  logic                      r_drop;
  logic                      w_pop, w_load;
  logic [REQ_DATA_WIDTH:0]   w_sum;
  logic [REQ_DATA_WIDTH-1:0] w_shifted;

  calc_entry_t               w_pop_entry;
  logic                      w_full, w_empty;
  logic [CNT_W-1:0]          w_count;
  logic                      w_count_unused;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_in_next = r_in_state;
    w_push    = 1'b0;
    if (r_in_state == IN_IDLE) begin
      if (bus.ifReq_cmd_in != NOP) w_in_next = IN_OPND2;
    end else begin
      w_push    = 1'b1;
      w_in_next = IN_IDLE;
    end
  end

  always_ff @(posedge ifClk) begin
    if (ifRst) begin
      r_in_state <= IN_IDLE;
      r_req_cmd  <= '0;
      r_req_tag  <= '0;
      r_req_op1  <= '0;
    end else begin
      r_in_state <= w_in_next;
      if (r_in_state == IN_IDLE && bus.ifReq_cmd_in != NOP) begin
        r_req_cmd <= bus.ifReq_cmd_in;
        r_req_tag <= bus.ifReq_tag_in;
        r_req_op1 <= bus.ifReq_data_in;
      end
    end
  end

  assign w_push_entry = '{cmd: r_req_cmd, tag: r_req_tag, op1: r_req_op1, op2: bus.ifReq_data_in};

  calc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (ifClk),
    .i_rst   (ifRst),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .o_entry (w_pop_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Occupancy is exported for observation only; the responder needs full/empty.
  assign w_count_unused = ^w_count;

  assign w_sum     = {1'b0, r_op1} + {1'b0, r_op2};
  assign w_shifted = (r_cmd == SHL) ? {r_acc[30:0], 1'b0} : {1'b0, r_acc[31:1]};

  always_comb begin
    w_ex_next = r_ex_state;
    w_pop     = 1'b0;
    w_load    = 1'b0;
    w_resp    = NONE;
    w_data    = '0;
    case (r_ex_state)
      EX_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_ex_next = EX_EXEC;
        end
      end
      EX_EXEC: begin
        w_ex_next = EX_RESP;
        w_load    = 1'b1;
        w_resp    = ERR;
        case (r_cmd)
          ADD: if (!w_sum[REQ_DATA_WIDTH]) begin
            w_resp = OK;
            w_data = w_sum[REQ_DATA_WIDTH-1:0];
          end
          SUB: if (r_op2 <= r_op1) begin
            w_resp = OK;
            w_data = r_op1 - r_op2;
          end
          SHL, SHR: begin
            if (r_op2[4:0] == 5'd0) begin
              w_resp = OK;
              w_data = r_op1;
            end else begin
              w_load    = 1'b0;
              w_resp    = NONE;
              w_ex_next = EX_SHIFT;
            end
          end
          default: ;
        endcase
      end
      EX_SHIFT: begin
        if (r_cnt == 5'd1) begin
          w_load    = 1'b1;
          w_resp    = OK;
          w_data    = w_shifted;
          w_ex_next = EX_RESP;
        end
      end
      EX_RESP: w_ex_next = EX_IDLE;
      default: w_ex_next = EX_IDLE;
    endcase
  end

  always_ff @(posedge ifClk) begin
    if (ifRst) begin
      r_ex_state <= EX_IDLE;
      r_cmd      <= '0;
      r_tag      <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_resp     <= NONE;
      r_data     <= '0;
      r_tag_out  <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_ex_state <= w_ex_next;
      if (w_pop) begin
        r_cmd <= w_pop_entry.cmd;
        r_tag <= w_pop_entry.tag;
        r_op1 <= w_pop_entry.op1;
        r_op2 <= w_pop_entry.op2;
      end
      if (r_ex_state == EX_EXEC) begin
        r_acc <= r_op1;
        r_cnt <= r_op2[4:0];
      end else if (r_ex_state == EX_SHIFT) begin
        r_acc <= w_shifted;
        r_cnt <= r_cnt - 5'd1;
      end
      // Outputs carry a result only in the cycle after it is computed.
      r_resp    <= w_resp;
      r_data    <= w_data;
      r_tag_out <= w_load ? r_tag : '0;
      r_drop    <= w_push && w_full && !w_pop;
    end
  end

  assign bus.ifResp_out = r_resp;
  assign bus.ifData_out = r_data;
  assign bus.ifTag_out  = r_tag_out;
  assign bus.ifDrop_out = r_drop;

endmodule

// File: tb/tb_calc_port_responder.sv
// Self-checking bench for calc_port_responder: directed corner cases, random
// requests against an arithmetic reference model, FIFO overflow and reset.
module tb_calc_port_responder;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_port_responder_if bus ();

  calc_port_responder #(.FIFO_DEPTH(4)) dut (
    .ifClk (clk),
    .ifRst (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  tag;
    logic [1:0]  resp;
    logic [31:0] data;
  } obs_t;

  obs_t q[$];
  bit   mon_en = 1'b0;
  int   drops  = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.ifResp_out != 2'd0) q.push_back('{bus.ifTag_out, bus.ifResp_out, bus.ifData_out});
      if (bus.ifDrop_out) drops++;
    end
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Reference: result straight from the arithmetic rules; latency counted from the cmd cycle.
  function automatic void model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                output logic [1:0] r, output logic [31:0] d, output int lat);
    logic [63:0] s;
    logic [4:0]  n;
    n   = b[4:0];
    r   = 2'd2;
    d   = 32'd0;
    lat = 4;
    case (cmd)
      4'd1: begin
        s = 64'(a) + 64'(b);
        if (s <= 64'hFFFF_FFFF) begin r = 2'd1; d = s[31:0]; end
      end
      4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
      4'd5: begin r = 2'd1; d = a << n; lat = 4 + int'(n); end
      4'd6: begin r = 2'd1; d = a >> n; lat = 4 + int'(n); end
      default: ;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] cmd, input logic [1:0] tag, input logic [31:0] op1, input logic [31:0] op2);
    bus.ifReq_cmd_in  = cmd;
    bus.ifReq_tag_in  = tag;
    bus.ifReq_data_in = op1;
    step();
    bus.ifReq_cmd_in  = 4'd0;
    bus.ifReq_tag_in  = 2'd0;
    bus.ifReq_data_in = op2;
    step();
    bus.ifReq_data_in = 32'd0;
  endtask

  // Called right after send(): the next negedge lies in cycle T+2.
  task automatic expect_resp(input string name, input logic [1:0] tag, input logic [1:0] resp,
                             input logic [31:0] data, input int lat);
    bit quiet = 1'b1;
    for (int i = 0; i < lat - 2; i++) begin
      @(negedge clk);
      if (bus.ifResp_out != 2'd0 || bus.ifData_out != 32'd0) quiet = 1'b0;
    end
    check({name, ".early"}, 64'(quiet), 64'd1);
    @(negedge clk);
    check({name, ".resp"}, 64'(bus.ifResp_out), 64'(resp));
    check({name, ".data"}, 64'(bus.ifData_out), 64'(data));
    check({name, ".tag"},  64'(bus.ifTag_out),  64'(tag));
    @(negedge clk);
    check({name, ".after"}, {30'd0, bus.ifResp_out, bus.ifData_out}, 64'd0);
  endtask

  initial begin
    logic [3:0]  cmd;
    logic [1:0]  tag, r;
    logic [31:0] a, b, d;
    int          lat, sel, seen3;
    logic [1:0]  ov_tag [6];
    logic [1:0]  ov_r   [6];
    logic [31:0] ov_d   [6];
    obs_t        o;

    bus.ifReq_cmd_in  = 4'd0;
    bus.ifReq_tag_in  = 2'd0;
    bus.ifReq_data_in = 32'd0;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst.resp", 64'(bus.ifResp_out), 64'd0);
    check("rst.data", 64'(bus.ifData_out), 64'd0);
    check("rst.tag",  64'(bus.ifTag_out),  64'd0);
    check("rst.drop", 64'(bus.ifDrop_out), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Directed corner cases with hand-derived results
    send(4'd1, 2'd2, 32'd5, 32'd7);                 expect_resp("add", 2'd2, 2'd1, 32'd12, 4);
    send(4'd1, 2'd3, 32'hFFFF_FFFF, 32'd1);         expect_resp("add_ovf", 2'd3, 2'd2, 32'd0, 4);
    send(4'd2, 2'd0, 32'd3, 32'd4);                 expect_resp("sub_unf", 2'd0, 2'd2, 32'd0, 4);
    send(4'd2, 2'd1, 32'd4, 32'd3);                 expect_resp("sub_ok", 2'd1, 2'd1, 32'd1, 4);
    send(4'd5, 2'd2, 32'd1, 32'd4);                 expect_resp("shl4", 2'd2, 2'd1, 32'h10, 8);
    send(4'd6, 2'd3, 32'h8000_0000, 32'd31);        expect_resp("shr31", 2'd3, 2'd1, 32'd1, 35);
    send(4'd5, 2'd0, 32'hDEAD_BEEF, 32'h0000_0020); expect_resp("shl0", 2'd0, 2'd1, 32'hDEAD_BEEF, 4);
    send(4'd9, 2'd1, 32'd77, 32'd88);               expect_resp("invalid", 2'd1, 2'd2, 32'd0, 4);

    // Random requests against the reference model
    for (int k = 0; k < 24; k++) begin
      sel = int'($urandom_range(0, 9));
      a   = $urandom;
      b   = $urandom;
      tag = 2'($urandom_range(0, 3));
      case (sel)
        0, 1: cmd = 4'd1;
        2, 3: cmd = 4'd2;
        4:    cmd = 4'd5;
        5:    cmd = 4'd6;
        6: begin
          cmd = 4'($urandom_range(3, 15));
          if (cmd == 4'd5 || cmd == 4'd6) cmd = 4'd7;
        end
        7: begin cmd = 4'd1; a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); b = 32'($urandom_range(0, 31)); end
        8: begin cmd = 4'd2; b = a; end
        default: begin cmd = 4'($urandom_range(5, 6)); b = b & ~32'h1F; end
      endcase
      model(cmd, a, b, r, d, lat);
      send(cmd, tag, a, b);
      expect_resp($sformatf("rand%0d", k), tag, r, d, lat);
    end

    // Overflow: six back-to-back long shifts; the sixth must be dropped
    ov_tag = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    q.delete();
    drops  = 0;
    mon_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cmd = (k % 2 == 0) ? 4'd5 : 4'd6;
      a   = $urandom | 32'h8000_0001;
      b   = ($urandom & ~32'h1F) | 32'd31;
      model(cmd, a, b, ov_r[k], ov_d[k], lat);
      send(cmd, ov_tag[k], a, b);
    end
    for (int i = 0; i < 400 && q.size() < 5; i++) @(negedge clk);
    repeat (60) @(negedge clk);
    check("ovf.count", 64'(q.size()), 64'd5);
    check("ovf.drops", 64'(drops), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < q.size()) o = q[i];
      else o = 'x;
      check($sformatf("ovf%0d.tag", i),  64'(o.tag),  64'(ov_tag[i]));
      check($sformatf("ovf%0d.resp", i), 64'(o.resp), 64'(ov_r[i]));
      check($sformatf("ovf%0d.data", i), 64'(o.data), 64'(ov_d[i]));
    end
    seen3 = 0;
    foreach (q[i]) if (q[i].tag == 2'd3) seen3++;
    check("ovf.dropped_tag", 64'(seen3), 64'd0);

    // Reset while shifting with two entries queued
    q.delete();
    drops = 0;
    send(4'd6, 2'd1, 32'hF000_0000, 32'd31);
    send(4'd6, 2'd2, 32'hF000_0000, 32'd31);
    send(4'd6, 2'd3, 32'hF000_0000, 32'd31);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst.resp", 64'(bus.ifResp_out), 64'd0);
    check("mid_rst.data", 64'(bus.ifData_out), 64'd0);
    check("mid_rst.tag",  64'(bus.ifTag_out),  64'd0);
    check("mid_rst.drop", 64'(bus.ifDrop_out), 64'd0);
    repeat (150) @(negedge clk);
    check("mid_rst.silent", 64'(q.size()), 64'd0);
    mon_en = 1'b0;
    send(4'd1, 2'd3, 32'd100, 32'd23);
    expect_resp("post_rst_add", 2'd3, 2'd1, 32'd123, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_port_responder.md
# calc_port_responder

Single-port responder for the calculator request/response protocol: it receives requests on one requester port's cmd/data/tag inputs and returns one response on the resp/data/tag outputs. It is the DUT-side end of the channel that the bench driver writes and the monitor reads. It buffers up to FIFO_DEPTH requests, executes add/sub in one cycle and shifts iteratively, and returns responses in order. Four instances plus a port mux form the calculator stand-in used for bench bring-up.

## Interface
- FIFO_DEPTH, 4: accepted-request buffer entries, power of two.
- ifClk  input  1  clock; all state updates on the rising edge.
- ifRst  input  1  reset; synchronous, active-high.
- ifReq_cmd_in  input  REQ_CMD_WIDTH (4)  command; 0 = no-op.
- ifReq_data_in  input  REQ_DATA_WIDTH (32)  operand 1 in the cmd cycle; operand 2 in the following cycle.
- ifReq_tag_in  input  REQ_TAG_WIDTH (2)  request tag, sampled in the cmd cycle.
- ifResp_out  output  OUT_RESP_WIDTH (2)  0 = none, 1 = success, 2 = error, 3 = never driven.
- ifData_out  output  REQ_DATA_WIDTH  result; 0 when ifResp_out is not 1.
- ifTag_out  output  REQ_TAG_WIDTH  tag of the returned request.
- ifDrop_out  output  1  one-cycle pulse when a request is discarded because the FIFO is full.

## Operation
- Commands: 1 = add, 2 = sub, 5 = shift left, 6 = shift right. Any other nonzero value is invalid and returns resp 2 with data 0.
- Input FSM:
  - IDLE: cmd≠0 → latch cmd, op1, tag; go to OPND2.
  - OPND2: latch op2 from data, push {cmd, tag, op1, op2}; return to IDLE.
  - cmd is ignored during OPND2.
- Push: accepted if count < FIFO_DEPTH or a pop occurs in the same cycle. Otherwise the request is dropped and ifDrop_out pulses in the next cycle.
- Executor FSM:
  - IDLE: FIFO non-empty → pop the entry into work registers; go to EXEC.
  - EXEC, add: 33-bit sum; carry out → resp 2, data 0; else resp 1, data sum. Go to RESP.
  - EXEC, sub: op2 > op1 (unsigned) → resp 2, data 0; else resp 1, data op1−op2. Go to RESP.
  - EXEC, shift: count = op2[4:0]; acc = op1. count = 0 → RESP with data op1; else go to SHIFT.
  - SHIFT: acc shifts one bit per cycle (logical; zero fill), count decrements. count reaches 0 → RESP, resp 1, data acc.
  - RESP: outputs hold the result for exactly one cycle; go to IDLE.
- Responses return in acceptance order. Tags are passed through unchecked; duplicate tags are legal.

## Timing
- Reset values: ifResp_out 0, ifData_out 0, ifTag_out 0, ifDrop_out 0. FIFO is emptied and both FSMs go to IDLE.
- Outputs are registered. They are zero in every cycle that is not a RESP cycle.
- Latency for add/sub/invalid/shift-0: op2 in cycle T+1 → response valid in cycle T+4.
- Shift by n > 0: response valid in cycle T+4+n.
- A new cmd may appear in the cycle immediately after the op2 cycle, giving a request every 2 cycles.
- Executor throughput: one response every 3 cycles for single-cycle ops. Sustained input at one request per 2 cycles therefore fills the FIFO.
- Simultaneous push and pop on a full FIFO: both occur; count is unchanged; no drop.
- Reset mid-operation (OPND2, SHIFT or RESP): the pending request and all queued entries are discarded. No response is issued after reset.
- Pointers wrap modulo FIFO_DEPTH. count has width clog2(FIFO_DEPTH)+1.

## Structure
- Shared package calc_pkg:
  - width constants REQ_CMD_WIDTH, REQ_DATA_WIDTH, REQ_TAG_WIDTH, OUT_RESP_WIDTH;
  - cmd enum (NOP, ADD, SUB, SHL, SHR);
  - resp enum (NONE, OK, ERR);
  - calc_entry_t struct {cmd, tag, op1, op2}.
- Sub-module calc_cmd_fifo: synchronous FIFO of calc_entry_t with push, pop, full, empty and count. The responder instantiates it once.

## Test plan
- Add: cmd 1, tag 2, op1 5, op2 7 → in the 3rd cycle after op2: resp 1, data 12, tag 2, for one cycle only.
- Add overflow and sub underflow: add 0xFFFFFFFF + 1 → resp 2, data 0. Sub 3 − 4 → resp 2, data 0. Sub 4 − 3 → resp 1, data 1.
- Shifts: shift left 0x1 by 4 → data 0x10 at T+8. Shift right 0x80000000 by 31 → data 1. Shift by 0 → data op1 at T+4.
- Invalid cmd 9, tag 1 → resp 2, data 0, tag 1.
- Overflow: 6 back-to-back shift-by-31 requests → in-order responses for the 5 accepted requests (4 buffered plus 1 popped), ifDrop_out pulses once, and the dropped tag is never returned.
- Reset: assert ifRst during SHIFT with 2 entries queued → all outputs 0 and no response after reset. A fresh add afterwards responds at T+4.
